// File: rtl/fft16_pkg.sv
// Shared constants for the 16-point radix-4 twiddle feeder: widths, Q2.14 twiddle
// values (cos, -sin) for the exponents a 4x4 radix-4 split can produce, and the exponent rule.
package fft16_pkg;

    localparam int DW_DEF  = 16;
    localparam int TW_DEF  = 16;
    localparam int Q14_ONE = 16384;

    localparam logic signed [15:0] W_E0_RE = 16'(Q14_ONE);
    localparam logic signed [15:0] W_E0_IM = 16'sd0;
    localparam logic signed [15:0] W_E1_RE = 16'sd15137;
    localparam logic signed [15:0] W_E1_IM = -16'sd6270;
    localparam logic signed [15:0] W_E2_RE = 16'sd11585;
    localparam logic signed [15:0] W_E2_IM = -16'sd11585;
    localparam logic signed [15:0] W_E3_RE = 16'sd6270;
    localparam logic signed [15:0] W_E3_IM = -16'sd15137;
    localparam logic signed [15:0] W_E4_RE = 16'sd0;
    localparam logic signed [15:0] W_E4_IM = -16'sd16384;
    localparam logic signed [15:0] W_E6_RE = -16'sd11585;
    localparam logic signed [15:0] W_E6_IM = -16'sd11585;
    localparam logic signed [15:0] W_E9_RE = -16'sd15137;
    localparam logic signed [15:0] W_E9_IM = 16'sd6270;

    typedef enum logic {RD_EMPTY, RD_EMIT} rd_state_t;

    // n1 = idx[1:0], k1 = idx[3:2]; the 4-bit product is already modulo 16.
    function automatic logic [3:0] tw_exponent(input logic [3:0] idx);
        return {2'b00, idx[1:0]} * {2'b00, idx[3:2]};
    endfunction

endpackage

// File: rtl/fft16_twiddle_feeder_if.sv
// Sample-in / pair-out stream bundle of the twiddle feeder; slave is the feeder's view.
interface fft16_twiddle_feeder_if #(
    parameter int DW = 16,
    parameter int TW = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_real;
    logic signed [DW-1:0] in_imag;
    logic                 inverse;

    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_real;
    logic signed [DW-1:0] out_imag;
    logic signed [TW-1:0] tw_real;
    logic signed [TW-1:0] tw_imag;
    logic [3:0]           out_index;
    logic                 out_last;

    modport slave (
        input  in_valid, in_real, in_imag, inverse, out_ready,
        output in_ready, out_valid, out_real, out_imag, tw_real, tw_imag,
        output out_index, out_last
    );

    modport master (
        output in_valid, in_real, in_imag, inverse, out_ready,
        input  in_ready, out_valid, out_real, out_imag, tw_real, tw_imag,
        input  out_index, out_last
    );
endinterface

// File: rtl/fft16_twiddle_rom.sv
// Combinational W16^e lookup; inverse frames get the conjugate (imag negated).
module fft16_twiddle_rom
    import fft16_pkg::*;
#(
    parameter int TW = TW_DEF
) (
    input  logic [3:0]           i_exp,
    input  logic                 i_inverse,
    output logic signed [TW-1:0] o_tw_real,
    output logic signed [TW-1:0] o_tw_imag
);

    logic signed [15:0] w_re;
    logic signed [15:0] w_im;

    // Exponents outside {0,1,2,3,4,6,9} cannot occur for a 4x4 split.
    always_comb begin
        w_re = 16'sd0;
        w_im = 16'sd0;
        case (i_exp)
            4'd0: begin w_re = W_E0_RE; w_im = W_E0_IM; end
            4'd1: begin w_re = W_E1_RE; w_im = W_E1_IM; end
            4'd2: begin w_re = W_E2_RE; w_im = W_E2_IM; end
            4'd3: begin w_re = W_E3_RE; w_im = W_E3_IM; end
            4'd4: begin w_re = W_E4_RE; w_im = W_E4_IM; end
            4'd6: begin w_re = W_E6_RE; w_im = W_E6_IM; end
            4'd9: begin w_re = W_E9_RE; w_im = W_E9_IM; end
            default: begin w_re = 16'sd0; w_im = 16'sd0; end
        endcase
    end

    assign o_tw_real = TW'(w_re);
    assign o_tw_imag = i_inverse ? -TW'(w_im) : TW'(w_im);

endmodule

// File: rtl/fft16_twiddle_feeder.sv
// Ping-pong 16-sample frame buffer replaying each frame in index order with its twiddle;
// first pair valid 1 cycle after the 16th accept; in_ready falls only when both banks are full.
module fft16_twiddle_feeder
    import fft16_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int TW = TW_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    fft16_twiddle_feeder_if.slave  bus
);

    logic signed [DW-1:0] r_buf_re [2][16];
    logic signed [DW-1:0] r_buf_im [2][16];

    logic [1:0] r_full;
    logic [1:0] r_inv;
    logic       r_inv_cur;
    logic       r_wr_bank;
    logic [3:0] r_wr_cnt;
    logic       r_rd_bank;
    rd_state_t  r_state;

    logic signed [DW-1:0] r_out_re;
    logic signed [DW-1:0] r_out_im;
    logic signed [TW-1:0] r_tw_re;
    logic signed [TW-1:0] r_tw_im;
    logic [3:0]           r_out_idx;
    logic                 r_out_last;

    logic                 w_in_ready;
    logic                 w_in_fire;
    logic                 w_set_full;
    rd_state_t            w_state_nxt;
    logic                 w_load;
    logic                 w_ld_bank;
    logic [3:0]           w_ld_idx;
    logic                 w_rd_done;
    logic signed [TW-1:0] w_rom_re;
    logic signed [TW-1:0] w_rom_im;

    assign w_in_ready = !r_full[r_wr_bank];
    assign w_in_fire  = bus.in_valid && w_in_ready;
    assign w_set_full = w_in_fire && (r_wr_cnt == 4'd15);

    // Write side: the writer only ever targets a non-full bank, the reader a full one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_bank <= 1'b0;
            r_wr_cnt  <= 4'd0;
            r_inv_cur <= 1'b0;
            r_inv     <= 2'b00;
        end else if (w_in_fire) begin
            r_wr_cnt <= r_wr_cnt + 4'd1;
            if (r_wr_cnt == 4'd0)
                r_inv_cur <= bus.inverse;
            if (w_set_full) begin
                r_inv[r_wr_bank] <= r_inv_cur;
                r_wr_bank        <= ~r_wr_bank;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_buf_re[r_wr_bank][r_wr_cnt] <= bus.in_real;
            r_buf_im[r_wr_bank][r_wr_cnt] <= bus.in_imag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full <= 2'b00;
        end else begin
            if (w_set_full)
                r_full[r_wr_bank] <= 1'b1;
            if (w_rd_done)
                r_full[r_rd_bank] <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= RD_EMPTY;
            r_rd_bank <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_rd_done)
                r_rd_bank <= ~r_rd_bank;
        end
    end

    // The output register is the single pipeline stage: loading it is what advances the read.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_ld_bank   = r_rd_bank;
        w_ld_idx    = 4'd0;
        w_rd_done   = 1'b0;
        case (r_state)
            RD_EMPTY: begin
                if (r_full[r_rd_bank]) begin
                    w_load      = 1'b1;
                    w_state_nxt = RD_EMIT;
                end
            end
            RD_EMIT: begin
                if (bus.out_ready) begin
                    if (r_out_idx != 4'd15) begin
                        w_load   = 1'b1;
                        w_ld_idx = r_out_idx + 4'd1;
                    end else begin
                        w_rd_done = 1'b1;
                        w_ld_bank = ~r_rd_bank;
                        if (r_full[~r_rd_bank])
                            w_load = 1'b1;
                        else
                            w_state_nxt = RD_EMPTY;
                    end
                end
            end
            default: w_state_nxt = RD_EMPTY;
        endcase
    end

    fft16_twiddle_rom #(
        .TW (TW)
    ) u_rom (
        .i_exp     (tw_exponent(w_ld_idx)),
        .i_inverse (r_inv[w_ld_bank]),
        .o_tw_real (w_rom_re),
        .o_tw_imag (w_rom_im)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_re   <= '0;
            r_out_im   <= '0;
            r_tw_re    <= '0;
            r_tw_im    <= '0;
            r_out_idx  <= 4'd0;
            r_out_last <= 1'b0;
        end else if (w_load) begin
            r_out_re   <= r_buf_re[w_ld_bank][w_ld_idx];
            r_out_im   <= r_buf_im[w_ld_bank][w_ld_idx];
            r_tw_re    <= w_rom_re;
            r_tw_im    <= w_rom_im;
            r_out_idx  <= w_ld_idx;
            r_out_last <= (w_ld_idx == 4'd15);
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == RD_EMIT);
    assign bus.out_real  = r_out_re;
    assign bus.out_imag  = r_out_im;
    assign bus.tw_real   = r_tw_re;
    assign bus.tw_imag   = r_tw_im;
    assign bus.out_index = r_out_idx;
    assign bus.out_last  = r_out_last;

endmodule

// File: tb/tb_fft16_twiddle_feeder.sv
// Bench for the twiddle feeder: twiddles derived from cos/sin of 2*pi*e/16 in a frame-level model.
module tb_fft16_twiddle_feeder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fft16_twiddle_feeder_if #(.DW(16), .TW(16)) bus ();

    fft16_twiddle_feeder #(.DW(16), .TW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic man_ready = 1'b0;
    logic rnd_ready = 1'b0;
    logic rnd_en    = 1'b0;
    assign bus.out_ready = rnd_en ? rnd_ready : man_ready;

    int n_checks = 0;
    int n_fail   = 0;
    int n_beats  = 0;
    int stall_cnt = 0;

    typedef struct {
        int re; int im; int twr; int twi; int idx; bit last; bit inv;
    } beat_t;
    beat_t exp_q[$];

    int stg_re [16];
    int stg_im [16];
    int stg_n  = 0;
    bit stg_inv = 0;

    int  obs_twr [2][16];
    int  obs_twi [2][16];
    bit  obs_last[2][16];

    bit    prev_stall = 0;
    beat_t held;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic finish_now();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out", name);
        finish_now();
    endtask

    function automatic int rnd(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    endfunction

    // Frame-level reference: a completed frame yields 16 beats with W16^((i%4)*(i/4) mod 16).
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            stg_n      = 0;
            prev_stall = 0;
        end else begin
            if (bus.out_valid) begin
                if (prev_stall) begin
                    check("stall_hold_data", {bus.out_real, bus.out_imag}, {held.re[15:0], held.im[15:0]});
                    check("stall_hold_index", bus.out_index, held.idx);
                end
                held.re  = bus.out_real;
                held.im  = bus.out_imag;
                held.idx = bus.out_index;
                if (bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 1, 0);
                    end else begin
                        beat_t e;
                        e = exp_q.pop_front();
                        check("beat_data", {bus.out_real, bus.out_imag}, {e.re[15:0], e.im[15:0]});
                        check("beat_tw_real", bus.tw_real, e.twr);
                        check("beat_tw_imag", bus.tw_imag, e.twi);
                        check("beat_index", bus.out_index, e.idx);
                        check("beat_last", bus.out_last, e.last);
                        obs_twr[e.inv][e.idx]  = bus.tw_real;
                        obs_twi[e.inv][e.idx]  = bus.tw_imag;
                        obs_last[e.inv][e.idx] = bus.out_last;
                    end
                    n_beats++;
                end
                prev_stall = !bus.out_ready;
            end else begin
                if (prev_stall)
                    check("valid_dropped_in_stall", 0, 1);
                prev_stall = 0;
            end
            if (bus.in_valid && bus.in_ready) begin
                if (stg_n == 0)
                    stg_inv = bus.inverse;
                stg_re[stg_n] = bus.in_real;
                stg_im[stg_n] = bus.in_imag;
                stg_n++;
                if (stg_n == 16) begin
                    for (int i = 0; i < 16; i++) begin
                        beat_t b;
                        int    e;
                        real   ang;
                        e     = ((i % 4) * (i / 4)) % 16;
                        ang   = 2.0 * 3.14159265358979 * e / 16.0;
                        b.re  = stg_re[i];
                        b.im  = stg_im[i];
                        b.twr = rnd(16384.0 * $cos(ang));
                        b.twi = rnd(-16384.0 * $sin(ang));
                        if (stg_inv)
                            b.twi = -b.twi;
                        b.idx  = i;
                        b.last = (i == 15);
                        b.inv  = stg_inv;
                        exp_q.push_back(b);
                    end
                    stg_n = 0;
                end
            end
        end
    end

    task automatic push(input int re, input int im, input bit inv);
        int t;
        bit acc;
        t   = 0;
        acc = 0;
        bus.in_valid = 1'b1;
        bus.in_real  = 16'(re);
        bus.in_imag  = 16'(im);
        bus.inverse  = inv;
        while (!acc) begin
            @(negedge clk);
            acc = bus.in_ready;
            if (!acc)
                stall_cnt++;
            @(posedge clk);
            #1;
            t++;
            if (t > 2000)
                timeout("push_accept");
        end
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 || bus.out_valid) begin
            cycles(1);
            t++;
            if (t > 3000)
                timeout("drain");
        end
    endtask

    typedef struct { int idx; bit inv; int twr; int twi; bit last; } vec_t;
    vec_t vecs [7];

    initial begin
        vecs[0] = '{0,  1'b0, 16384,  0,      1'b0};
        vecs[1] = '{5,  1'b0, 15137,  -6270,  1'b0};
        vecs[2] = '{10, 1'b0, 0,      -16384, 1'b0};
        vecs[3] = '{15, 1'b0, -15137, 6270,   1'b1};
        vecs[4] = '{5,  1'b1, 15137,  6270,   1'b0};
        vecs[5] = '{9,  1'b1, 11585,  11585,  1'b0};
        vecs[6] = '{15, 1'b1, -15137, -6270,  1'b1};

        bus.in_valid = 1'b0;
        bus.in_real  = '0;
        bus.in_imag  = '0;
        bus.inverse  = 1'b0;

        // Reset state
        cycles(3);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_outputs", {bus.out_real, bus.out_imag, bus.tw_real, bus.tw_imag, bus.out_index, bus.out_last}, 0);
        rst = 1'b0;
        cycles(1);
        check("reset_in_ready", bus.in_ready, 1);

        // Basic frame: valid rises one cycle after the 16th accept, then 16 consecutive beats.
        man_ready = 1'b1;
        for (int i = 0; i < 16; i++)
            push(i, -i, 1'b0);
        idle();
        check("basic_valid_not_yet", bus.out_valid, 0);
        cycles(1);
        check("basic_valid_rise", bus.out_valid, 1);
        check("basic_first_index", bus.out_index, 0);
        begin
            int cnt;
            cnt = 0;
            for (int k = 0; k < 16; k++) begin
                if (bus.out_valid)
                    cnt++;
                cycles(1);
            end
            check("basic_consecutive_beats", cnt, 16);
            check("basic_valid_after_frame", bus.out_valid, 0);
        end
        drain();

        // Back-to-back: three frames streamed, all 48 beats in order with at most a bubble per frame.
        stall_cnt = 0;
        fork
            begin
                for (int i = 0; i < 48; i++)
                    push(1000 + i, 2000 - i, 1'b0);
                idle();
            end
            begin
                int t0, span, b0;
                t0 = 0;
                while (!bus.out_valid) begin
                    cycles(1);
                    t0++;
                    if (t0 > 200) timeout("b2b_first_valid");
                end
                b0   = n_beats;
                span = 0;
                while (n_beats - b0 < 48) begin
                    cycles(1);
                    span++;
                    if (span > 300) timeout("b2b_beats");
                end
                check("b2b_span_ok", (span <= 50) ? 1 : 0, 1);
            end
        join
        check("b2b_in_ready_stalls_ok", (stall_cnt <= 2) ? 1 : 0, 1);
        drain();

        // Backpressure: 32 samples fill both banks while the output holds index 0.
        man_ready = 1'b0;
        for (int i = 0; i < 32; i++)
            push(300 + i, -300 - i, 1'b0);
        idle();
        check("bp_in_ready_low", bus.in_ready, 0);
        cycles(5);
        check("bp_valid_held", bus.out_valid, 1);
        check("bp_index_frozen", bus.out_index, 0);
        check("bp_data_frozen", bus.out_real, 300);
        check("bp_in_ready_still_low", bus.in_ready, 0);
        man_ready = 1'b1;
        begin
            int t;
            t = 0;
            forever begin
                @(negedge clk);
                if (bus.out_valid && bus.out_index == 4'd15) break;
                t++;
                if (t > 100) timeout("bp_idx15");
            end
            check("bp_in_ready_before_free", bus.in_ready, 0);
            @(posedge clk);
            #1;
            check("bp_in_ready_after_free", bus.in_ready, 1);
        end
        drain();

        // Inverse latched at index 0 even though it toggles during the frame.
        for (int i = 0; i < 16; i++)
            push(100 + i, 3 * i, (i == 0) ? 1'b1 : 1'(i % 2));
        for (int i = 0; i < 16; i++)
            push(200 + i, -7 * i, (i == 0) ? 1'b0 : 1'b1);
        idle();
        drain();
        for (int v = 0; v < 7; v++) begin
            check($sformatf("vec%0d_tw_real", v), obs_twr[vecs[v].inv][vecs[v].idx], vecs[v].twr);
            check($sformatf("vec%0d_tw_imag", v), obs_twi[vecs[v].inv][vecs[v].idx], vecs[v].twi);
            check($sformatf("vec%0d_last", v), obs_last[vecs[v].inv][vecs[v].idx], vecs[v].last);
        end

        // Random out_ready and input gaps over four frames.
        rnd_en = 1'b1;
        fork
            while (rnd_en) begin
                @(posedge clk);
                #1;
                rnd_ready = 1'($urandom_range(0, 1));
            end
        join_none
        for (int i = 0; i < 64; i++) begin
            push(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
                 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                idle();
                cycles(1);
            end
        end
        idle();
        drain();
        rnd_en = 1'b0;
        cycles(2);

        // Reset while frame 1 drains and frame 2 is 7 samples in.
        man_ready = 1'b1;
        for (int i = 0; i < 16; i++)
            push(500 + i, i, 1'b0);
        for (int i = 0; i < 7; i++)
            push(600 + i, i, 1'b0);
        check("rst_pre_mid_drain", bus.out_valid, 1);
        rst = 1'b1;
        #1;
        check("rst_async_valid", bus.out_valid, 0);
        idle();
        cycles(2);
        rst = 1'b0;
        cycles(1);
        check("rst_in_ready", bus.in_ready, 1);
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 20; k++) begin
                if (bus.out_valid) seen++;
                cycles(1);
            end
            check("rst_no_stale_outputs", seen, 0);
        end
        for (int i = 0; i < 16; i++)
            push(700 + i, -i, 1'b0);
        idle();
        cycles(1);
        check("rst_fresh_valid", bus.out_valid, 1);
        check("rst_fresh_index", bus.out_index, 0);
        check("rst_fresh_data", bus.out_real, 700);
        drain();

        finish_now();
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/fft16_twiddle_feeder.md
Name: fft16_twiddle_feeder

Overview:
- Sits between the first radix-4 butterfly stage and the complex fast multiplier in the 16-point radix-4 FFT.
- Buffers 16-sample frames of stage-1 butterfly outputs in a ping-pong buffer.
- Replays each frame in index order, paired with its twiddle factor W16^e from an internal ROM.
- Valid/ready on both sides; one frame loads while the other drains.

Parameters:
- DW, 16, signed width of each sample real/imag component.
- TW, 16, signed width of twiddle components, Q2.14 format (1.0 = 16384).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept an input sample.
- in_real  in  DW  sample real part.
- in_imag  in  DW  sample imaginary part.
- inverse  in  1  1 = conjugate twiddles (IFFT). Sampled with input index 0 and held for that frame.
- out_valid  out  1  output pair valid.
- out_ready  in  1  multiplier accepts the pair.
- out_real, out_imag  out  DW  buffered sample.
- tw_real, tw_imag  out  TW  twiddle for this sample.
- out_index  out  4  sample index within the frame.
- out_last  out  1  high with index 15.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high. On rst:
  - both banks empty, write bank 0, read bank 0, counters 0;
  - in_ready=1 after reset deasserts;
  - out_valid=0 and all output data/twiddle/index/last = 0.
- Input transfer: occurs when in_valid && in_ready.
  - Write to wr_bank[wr_cnt], then wr_cnt++.
  - On wr_cnt==15 transfer: mark the bank full, latch the frame's inverse flag, toggle wr_bank, wr_cnt wraps to 0.
- in_ready = !full[wr_bank]. Deasserts only when both banks are full.
- Read FSM states: EMPTY, EMIT.
  - EMPTY -> EMIT when full[rd_bank]. Output register loads element 0 on that edge, so out_valid rises 1 cycle after the 16th input accept.
  - EMIT: on out_valid && out_ready, load the next element on the same edge (back-to-back throughput of 1 per cycle).
  - After the index-15 transfer: clear full[rd_bank], toggle rd_bank. Go to EMIT with element 0 of the other bank if that bank is full, else EMPTY.
- Stall: outputs held stable while out_valid && !out_ready.
- Twiddle exponent for index i: n1=i[1:0], k1=i[3:2], e=(n1*k1) mod 16. Possible e: 0,1,2,3,4,6,9.
  - ROM values (cos, -sin):
    - e0=(16384,0)
    - e1=(15137,-6270)
    - e2=(11585,-11585)
    - e3=(6270,-15137)
    - e4=(0,-16384)
    - e6=(-11585,-11585)
    - e9=(-15137,6270)
  - inverse frame: tw_imag is negated. No saturation is needed, since all values are within ±16384.
- Sample data passes through unmodified; no arithmetic on samples.
- Simultaneous events:
  - Write completing bank A while read completes bank B in the same cycle: both full-flag updates apply. Set and clear target different banks, so there is no conflict.
  - in_ready reasserts the cycle after a bank is freed (registered flags).
- Reset mid-frame: partial input frame and pending outputs are discarded, with no outputs after reset until 16 new samples are loaded.

Decomposition:
- Shared package fft16_pkg: DW/TW defaults, Q2.14 ONE=16384, the seven twiddle constants, and the exponent function.
- One sub-module, fft16_twiddle_rom: combinational 4-bit exponent + inverse -> tw_real/tw_imag.
- Buffer is a 2x16 register array inside the top.

Test Plan:
- Basic frame: reset, stream 16 samples real=i, imag=-i with out_ready=1.
  - out_valid rises 1 cycle after the 16th accept, then emits 16 consecutive cycles.
  - i=5 gives tw=(15137,-6270); i=10 gives (0,-16384); i=15 gives (-15137,6270), out_last=1.
- Back-to-back: three frames with in_valid held high and out_ready=1.
  - in_ready never drops; output is continuous 48 beats, indices 0..15 repeating.
- Backpressure: out_ready=0 while feeding 32 samples.
  - in_ready drops after the 32nd accept, and outputs stay frozen on index 0.
  - Releasing out_ready drains both frames; in_ready returns 1 cycle after index 15 of frame 1 is transferred.
- Inverse: frame with inverse=1 at index 0 (toggled mid-frame).
  - All tw_imag are negated for the whole frame; i=5 gives (15137,6270).
  - The next frame with inverse=0 is normal.
- Random out_ready: 50% toggling over 4 frames. Data order is preserved and twiddles match e=(n1*k1) mod 16 on every transfer.
- Reset mid-operation: assert rst after 7 inputs of frame 2 while frame 1 is mid-drain.
  - out_valid=0 immediately, in_ready=1 after release.
  - A fresh frame then emits correctly from index 0.
